// File: rtl/fft_mag_writer_pkg.sv
// Shared sizes, writer state encoding and saturating counter helper for the FFT magnitude writer.
package fft_pkg;

    localparam int unsigned FFT_LEN = 1024;
    localparam int unsigned ADDR_W  = $clog2(FFT_LEN);
    localparam int unsigned MAG_W   = 16;
    localparam int unsigned SMP_W   = 16;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_SYNC         = 2'd0,
        ST_CAPTURE      = 2'd1,
        ST_DRAIN        = 2'd2,
        ST_WAIT_SAMPLER = 2'd3
    } wr_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fft_mag_writer_if.sv
// FFT stream input, magnitude BRAM write port and sampler handshake of the magnitude writer.
interface fft_mag_writer_if;
    import fft_pkg::*;

    logic                    fft_valid;
    logic signed [SMP_W-1:0] fft_re;
    logic signed [SMP_W-1:0] fft_im;
    logic                    fft_last;
    logic                    fft_ready;
    logic [ADDR_W-1:0]       write_addr;
    logic [MAG_W-1:0]        write_data;
    logic                    write_enable;
    logic                    sampler_start;
    logic                    sampler_done;

    modport master (
        output fft_valid, fft_re, fft_im, fft_last, sampler_done,
        input  fft_ready, write_addr, write_data, write_enable, sampler_start
    );

    modport slave (
        input  fft_valid, fft_re, fft_im, fft_last, sampler_done,
        output fft_ready, write_addr, write_data, write_enable, sampler_start
    );
endinterface

// File: rtl/fft_mag_writer_mag_l1.sv
// Two-stage pipelined L1 magnitude |re|+|im| saturated to MAG_W, with valid/index tags carried alongside.
module mag_l1
    import fft_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid_i,
    input  logic [ADDR_W-1:0]       in_idx_i,
    input  logic signed [SMP_W-1:0] re_i,
    input  logic signed [SMP_W-1:0] im_i,
    output logic                    out_valid_o,
    output logic [ADDR_W-1:0]       out_idx_o,
    output logic [MAG_W-1:0]        out_mag_o
);

    localparam int unsigned ABS_W = SMP_W + 1;
    localparam logic [ABS_W-1:0] MAG_MAX = ABS_W'((1 << MAG_W) - 1);

    logic [ABS_W-1:0]  re_ext_c, im_ext_c;
    logic [ABS_W-1:0]  abs_re_d, abs_im_d, abs_re_q, abs_im_q;
    logic [ABS_W-1:0]  sum_c;
    logic [MAG_W-1:0]  mag_d;
    logic              v1_q, v2_q;
    logic [ADDR_W-1:0] idx1_q, idx2_q;
    logic [MAG_W-1:0]  mag_q;

    // Extra bit keeps |-32768| = 32768 exact before the saturating sum.
    always_comb begin
        re_ext_c = {re_i[SMP_W-1], re_i};
        im_ext_c = {im_i[SMP_W-1], im_i};
        abs_re_d = re_ext_c[ABS_W-1] ? (~re_ext_c + ABS_W'(1)) : re_ext_c;
        abs_im_d = im_ext_c[ABS_W-1] ? (~im_ext_c + ABS_W'(1)) : im_ext_c;
        sum_c    = abs_re_q + abs_im_q;
        mag_d    = (sum_c > MAG_MAX) ? MAG_W'(MAG_MAX) : MAG_W'(sum_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            idx1_q   <= '0;
            abs_re_q <= '0;
            abs_im_q <= '0;
            v2_q     <= 1'b0;
            idx2_q   <= '0;
            mag_q    <= '0;
        end else begin
            v1_q     <= in_valid_i;
            idx1_q   <= in_idx_i;
            abs_re_q <= abs_re_d;
            abs_im_q <= abs_im_d;
            v2_q     <= v1_q;
            idx2_q   <= idx1_q;
            mag_q    <= mag_d;
        end
    end

    assign out_valid_o = v2_q;
    assign out_idx_o   = idx2_q;
    assign out_mag_o   = mag_q;

endmodule

// File: rtl/fft_mag_writer.sv
// Frame-synchronising FFT magnitude writer: fills the magnitude BRAM one bin per beat and
// hands each complete frame to the peak-search sampler.
module fft_mag_writer
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fft_mag_writer_if.slave   bus,
    output logic [CNT_W-1:0]  dropped_frames,
    output logic [CNT_W-1:0]  frame_errors
);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              mid_q, mid_d;
    logic              drain_q, drain_d;
    logic              start_q, start_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              cap_c;
    logic              beat_last_c;
    logic              idx_end_c;
    logic              eff_mid_c;

    assign beat_last_c = bus.fft_valid & bus.fft_last;
    assign idx_end_c   = (idx_q == ADDR_W'(FFT_LEN - 1));
    // A beat arriving with sampler_done decides mid-frame status in the same cycle.
    assign eff_mid_c   = bus.fft_valid ? ~bus.fft_last : mid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SYNC;
            idx_q   <= '0;
            mid_q   <= 1'b0;
            drain_q <= 1'b0;
            start_q <= 1'b0;
            drop_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mid_q   <= mid_d;
            drain_q <= drain_d;
            start_q <= start_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC:         if (beat_last_c) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (bus.fft_valid && idx_end_c)
                    state_d = bus.fft_last ? ST_DRAIN : ST_SYNC;
            end
            ST_DRAIN:        if (drain_q) state_d = ST_WAIT_SAMPLER;
            ST_WAIT_SAMPLER: if (bus.sampler_done) state_d = eff_mid_c ? ST_SYNC : ST_CAPTURE;
            default:         state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        mid_d   = mid_q;
        drain_d = 1'b0;
        start_d = 1'b0;
        drop_d  = drop_q;
        err_d   = err_q;
        cap_c   = 1'b0;
        case (state_q)
            ST_SYNC: begin
                idx_d = '0;
                if (beat_last_c) drop_d = sat_inc(drop_q);
            end
            ST_CAPTURE: begin
                mid_d = 1'b0;
                if (bus.fft_valid) begin
                    cap_c = 1'b1;
                    if (bus.fft_last) begin
                        idx_d = '0;
                        if (!idx_end_c) err_d = sat_inc(err_q);
                    end else if (idx_end_c) begin
                        idx_d = '0;
                        err_d = sat_inc(err_q);
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN, ST_WAIT_SAMPLER: begin
                idx_d = '0;
                if (bus.fft_valid) mid_d = ~bus.fft_last;
                if (beat_last_c)   drop_d = sat_inc(drop_q);
                if (state_q == ST_DRAIN) begin
                    drain_d = 1'b1;
                    start_d = drain_q;
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    mag_l1 u_mag (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (cap_c),
        .in_idx_i    (idx_q),
        .re_i        (bus.fft_re),
        .im_i        (bus.fft_im),
        .out_valid_o (bus.write_enable),
        .out_idx_o   (bus.write_addr),
        .out_mag_o   (bus.write_data)
    );

    assign bus.fft_ready     = 1'b1;
    assign bus.sampler_start = start_q;
    assign dropped_frames    = drop_q;
    assign frame_errors      = err_q;

endmodule
